timer_cascade_gen: RTL and testbench

- Parametrised MM:SS-style timer/stopwatch core, successor to the fixed 2-pair cascaded counter.
- Holds PAIRS digit pairs, each a units digit (0-9) and a tens digit (0-5), e.g. PAIRS=2 gives 00:00..59:59.
- Adds count-down mode, preload, pause/resume, terminal detection and a done pulse.
- Clocked at the system clock and advanced by a one-cycle tick from the clock divider; its outputs feed the 7-segment decoders.

---
 rtl/timer_cascade_gen_pkg.sv | 20 ++
 rtl/timer_cascade_gen_bcd_digit_cell.sv | 36 +++
 rtl/timer_cascade_gen.sv | 129 ++++++++++++
 tb/tb_timer_cascade_gen.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_cascade_gen_pkg.sv
// Shared definitions for the cascaded MM:SS timer: FSM states, digit limits
// and the preload clamp helper.
package timer_cascade_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [3:0] UNITS_MAX = 4'd9;
  localparam logic [3:0] TENS_MAX  = 4'd5;

  function automatic logic [3:0] clamp_nibble(input logic [3:0] val,
                                              input logic [3:0] max);
    return (val > max) ? max : val;
  endfunction

endpackage

// File: rtl/timer_cascade_gen_bcd_digit_cell.sv
// One BCD digit of the cascade: counts 0..MAX up or down when enabled,
// with a synchronous preload that overrides counting.
module bcd_digit_cell #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       down,
  input  logic       ld,
  input  logic [3:0] ld_val,
  output logic [3:0] q,
  output logic       at_max,
  output logic       at_min
);

  logic [3:0] r_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, regardless of the order the blocks are evaluated in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= 4'd0;
    end else if (ld) begin
      r_q <= ld_val;
    end else if (en) begin
      if (down) r_q <= at_min ? MAX : r_q - 4'd1;
      else      r_q <= at_max ? 4'd0 : r_q + 4'd1;
    end
  end

  assign q      = r_q;
  assign at_max = (r_q == MAX);
  assign at_min = (r_q == 4'd0);

endmodule

// File: rtl/timer_cascade_gen.sv
// Parametrised MM:SS timer/stopwatch: command FSM, preload clamp and terminal
// detection around a chain of BCD digit cells.
module timer_cascade_gen
  import timer_cascade_gen_pkg::*;
#(
  parameter  int PAIRS = 2,
  parameter  bit WRAP  = 1'b1,
  localparam int W     = 8 * PAIRS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic         start,
  input  logic         stop,
  input  logic         clear,
  input  logic         mode_down,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] digits,
  output logic         running,
  output logic         at_zero,
  output logic         done
);

  localparam int ND = 2 * PAIRS;

  state_e          r_state;
  state_e          w_state_nxt;
  logic            r_mode_down;
  logic            r_running;
  logic            r_done;
  logic            w_done_nxt;

  logic [ND-1:0]   w_en;
  logic [ND-1:0]   w_at_max;
  logic [ND-1:0]   w_at_min;
  logic            w_ld;
  logic            w_load_acc;
  logic            w_stop_acc;
  logic            w_start_acc;
  logic            w_step;
  logic            w_all_max;
  logic            w_one_left;
  logic            w_up_term;
  logic            w_dn_term;

  assign w_all_max  = &w_at_max;
  assign at_zero    = &w_at_min;
  assign w_one_left = (digits[3:0] == 4'd1) && (&w_at_min[ND-1:1]);

  // Only commands the current state accepts take part in the priority chain.
  assign w_load_acc  = load & ~clear & (r_state != ST_RUN);
  assign w_stop_acc  = stop & ~clear & (r_state == ST_RUN);
  assign w_start_acc = start & ~clear & ~w_load_acc &
                       (((r_state == ST_IDLE) & ~(mode_down & at_zero)) |
                        (r_state == ST_PAUSE));
  assign w_step      = tick & ~clear & ~stop & (r_state == ST_RUN);
  assign w_ld        = clear | w_load_acc;

  assign w_up_term = w_step & ~r_mode_down & w_all_max;
  assign w_dn_term = w_step &  r_mode_down & w_one_left;

  // Ripple enable: each digit steps only when every lower digit wraps.
  always_comb begin
    w_en[0] = w_step & ~(w_up_term & !WRAP);
    for (int i = 1; i < ND; i++) begin
      w_en[i] = w_en[i-1] & (r_mode_down ? w_at_min[i-1] : w_at_max[i-1]);
    end
  end

  for (genvar i = 0; i < ND; i++) begin : g_digit
    localparam logic [3:0] L_MAX = ((i % 2) == 1) ? TENS_MAX : UNITS_MAX;
    logic [3:0] w_ld_val;

    assign w_ld_val = clear ? 4'd0 : clamp_nibble(load_val[4*i +: 4], L_MAX);

    bcd_digit_cell #(.MAX(L_MAX)) u_cell (
      .clk    (clk),
      .rst    (rst),
      .en     (w_en[i]),
      .down   (r_mode_down),
      .ld     (w_ld),
      .ld_val (w_ld_val),
      .q      (digits[4*i +: 4]),
      .at_max (w_at_max[i]),
      .at_min (w_at_min[i])
    );
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    if (clear) begin
      w_state_nxt = ST_IDLE;
    end else if (w_load_acc) begin
      if (r_state == ST_DONE) w_state_nxt = ST_IDLE;
    end else if (w_stop_acc) begin
      w_state_nxt = ST_PAUSE;
    end else if (w_start_acc) begin
      w_state_nxt = ST_RUN;
    end else if (w_up_term) begin
      w_done_nxt = 1'b1;
      if (!WRAP) w_state_nxt = ST_DONE;
    end else if (w_dn_term) begin
      w_done_nxt  = 1'b1;
      w_state_nxt = ST_DONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_running   <= 1'b0;
      r_done      <= 1'b0;
      r_mode_down <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_running <= (w_state_nxt == ST_RUN);
      r_done    <= w_done_nxt;
      if (w_start_acc) r_mode_down <= mode_down;
    end
  end

  assign running = r_running;
  assign done    = r_done;

endmodule

// File: tb/tb_timer_cascade_gen.sv
// Bench for timer_cascade_gen (PAIRS=2): a wrapping and a saturating instance
// share stimulus and are compared against an integer-seconds reference model.
module tb_timer_cascade_gen;

  localparam int PAIRS = 2;
  localparam int W     = 8 * PAIRS;
  localparam int MAXV  = 3599;

  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;
  localparam int S_DONE  = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         tick, start, stop, clear, mode_down, load;
  logic [W-1:0] load_val;

  logic [W-1:0] dig_w, dig_s;
  logic         run_w, run_s, az_w, az_s, done_w, done_s;

  int n_checks = 0;
  int n_errors = 0;

  int m_st   [2];
  int m_cnt  [2];
  bit m_dn   [2];
  bit m_done [2];

  always #5 clk = ~clk;

  timer_cascade_gen #(.PAIRS(PAIRS), .WRAP(1'b1)) u_dut_wrap (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop),
    .clear(clear), .mode_down(mode_down), .load(load), .load_val(load_val),
    .digits(dig_w), .running(run_w), .at_zero(az_w), .done(done_w)
  );

  timer_cascade_gen #(.PAIRS(PAIRS), .WRAP(1'b0)) u_dut_sat (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop),
    .clear(clear), .mode_down(mode_down), .load(load), .load_val(load_val),
    .digits(dig_s), .running(run_s), .at_zero(az_s), .done(done_s)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Seconds count -> packed BCD, base 60 per pair.
  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] res;
    int r;
    res = '0;
    for (int p = 0; p < PAIRS; p++) begin
      r = v % 60;
      res[8*p +: 4]     = 4'(r % 10);
      res[8*p + 4 +: 4] = 4'(r / 10);
      v = v / 60;
    end
    return res;
  endfunction

  // Packed preload value -> seconds count, with out-of-range digits clamped.
  function automatic int from_lv(input logic [W-1:0] lv);
    int v, u, t;
    v = 0;
    for (int p = PAIRS - 1; p >= 0; p--) begin
      u = int'(lv[8*p +: 4]);
      t = int'(lv[8*p + 4 +: 4]);
      if (u > 9) u = 9;
      if (t > 5) t = 5;
      v = v * 60 + t * 10 + u;
    end
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = S_IDLE; m_cnt[k] = 0; m_dn[k] = 1'b0; m_done[k] = 1'b0;
    end
  endtask

  task automatic model_cycle();
    for (int k = 0; k < 2; k++) begin
      m_done[k] = 1'b0;
      if (clear) begin
        m_cnt[k] = 0;
        m_st[k]  = S_IDLE;
      end else if (load && m_st[k] != S_RUN) begin
        m_cnt[k] = from_lv(load_val);
        if (m_st[k] == S_DONE) m_st[k] = S_IDLE;
      end else if (stop && m_st[k] == S_RUN) begin
        m_st[k] = S_PAUSE;
      end else if (start && ((m_st[k] == S_IDLE && !(mode_down && m_cnt[k] == 0))
                             || m_st[k] == S_PAUSE)) begin
        m_st[k] = S_RUN;
        m_dn[k] = mode_down;
      end else if (tick && m_st[k] == S_RUN) begin
        if (m_dn[k]) begin
          if (m_cnt[k] == 0) m_cnt[k] = MAXV;
          else begin
            m_cnt[k]--;
            if (m_cnt[k] == 0) begin m_done[k] = 1'b1; m_st[k] = S_DONE; end
          end
        end else if (m_cnt[k] == MAXV) begin
          m_done[k] = 1'b1;
          if (k == 0) m_cnt[k] = 0;
          else        m_st[k] = S_DONE;
        end else begin
          m_cnt[k]++;
        end
      end
    end
  endtask

  task automatic check_all();
    check("wrap_digits",  32'(dig_w),  32'(to_bcd(m_cnt[0])));
    check("wrap_running", 32'(run_w),  32'(m_st[0] == S_RUN));
    check("wrap_done",    32'(done_w), 32'(m_done[0]));
    check("wrap_at_zero", 32'(az_w),   32'(m_cnt[0] == 0));
    check("sat_digits",   32'(dig_s),  32'(to_bcd(m_cnt[1])));
    check("sat_running",  32'(run_s),  32'(m_st[1] == S_RUN));
    check("sat_done",     32'(done_s), 32'(m_done[1]));
    check("sat_at_zero",  32'(az_s),   32'(m_cnt[1] == 0));
  endtask

  // One clock with the given pulses; mode_down is a level driven separately.
  task automatic cyc(input bit c, input bit l, input logic [W-1:0] lv,
                     input bit sp, input bit st, input bit tk);
    clear = c; load = l; load_val = lv; stop = sp; start = st; tick = tk;
    @(posedge clk);
    model_cycle();
    #1;
    check_all();
    @(negedge clk);
    clear = 1'b0; load = 1'b0; stop = 1'b0; start = 1'b0; tick = 1'b0;
  endtask

  initial begin
    logic [W-1:0] lv;
    bit c, l, sp, st, tk;

    rst = 1'b1; tick = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
    mode_down = 1'b0; load = 1'b0; load_val = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst = 1'b0;
    @(negedge clk);

    // Asynchronous reset while running at 12:34.
    cyc(0, 1, 16'h1234, 0, 0, 0);
    cyc(0, 0, '0, 0, 1, 0);
    check("run_at_1234", 32'(dig_w), 32'h1234);
    #2 rst = 1'b1;
    model_reset();
    #1;
    check_all();
    check("async_rst_digits", 32'(dig_w), 32'h0);
    check("async_rst_running", 32'(run_w), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Up count across the minute boundary.
    cyc(0, 1, 16'h0058, 0, 0, 0);
    cyc(0, 0, '0, 0, 1, 0);
    cyc(0, 0, '0, 0, 0, 1);
    check("up_0059", 32'(dig_w), 32'h0059);
    cyc(0, 0, '0, 0, 0, 1);
    check("up_0100", 32'(dig_w), 32'h0100);
    cyc(0, 0, '0, 0, 0, 1);
    check("up_0101", 32'(dig_w), 32'h0101);
    check("up_no_done", 32'(done_w), 32'h0);

    // Terminal at 59:59: wrap versus saturate.
    cyc(0, 0, '0, 1, 0, 0);
    cyc(0, 1, 16'h5959, 0, 0, 0);
    cyc(0, 0, '0, 0, 1, 0);
    cyc(0, 0, '0, 0, 0, 1);
    check("wrap_to_zero", 32'(dig_w), 32'h0);
    check("wrap_done_pulse", 32'(done_w), 32'h1);
    check("wrap_still_run", 32'(run_w), 32'h1);
    check("sat_hold_max", 32'(dig_s), 32'h5959);
    check("sat_done_pulse", 32'(done_s), 32'h1);
    check("sat_stopped", 32'(run_s), 32'h0);
    cyc(0, 0, '0, 0, 0, 0);
    check("done_one_cycle", 32'(done_s), 32'h0);
    cyc(0, 0, '0, 0, 1, 0);
    check("sat_start_ignored", 32'(run_s), 32'h0);

    // Down count, down terminal and start ignored at zero.
    cyc(1, 0, '0, 0, 0, 0);
    mode_down = 1'b1;
    cyc(0, 1, 16'h0100, 0, 0, 0);
    cyc(0, 0, '0, 0, 1, 0);
    cyc(0, 0, '0, 0, 0, 1);
    check("down_0059", 32'(dig_w), 32'h0059);
    cyc(0, 0, '0, 1, 0, 0);
    cyc(0, 1, 16'h0001, 0, 0, 0);
    cyc(0, 0, '0, 0, 1, 0);
    cyc(0, 0, '0, 0, 0, 1);
    check("down_zero", 32'(dig_w), 32'h0);
    check("down_done", 32'(done_w), 32'h1);
    check("down_stopped", 32'(run_w), 32'h0);
    cyc(0, 0, '0, 0, 1, 0);
    cyc(1, 0, '0, 0, 0, 0);
    cyc(0, 0, '0, 0, 1, 0);
    check("idle_zero_start_ign", 32'(run_w), 32'h0);

    // Same-cycle command priority and preload clamping.
    mode_down = 1'b0;
    cyc(0, 1, 16'h0010, 0, 0, 0);
    cyc(0, 0, '0, 0, 1, 0);
    cyc(0, 0, '0, 1, 0, 1);
    check("stop_tick_hold", 32'(dig_w), 32'h0010);
    cyc(1, 1, 16'h1234, 0, 0, 0);
    check("clear_beats_load", 32'(dig_w), 32'h0);
    cyc(0, 1, 16'h0005, 0, 0, 0);
    cyc(0, 0, '0, 0, 1, 0);
    cyc(0, 1, 16'h0040, 0, 0, 0);
    check("load_in_run_ign", 32'(dig_w), 32'h0005);
    cyc(0, 0, '0, 1, 0, 0);
    cyc(0, 1, 16'h7F7F, 0, 0, 0);
    check("load_clamped", 32'(dig_w), 32'h5959);

    // Pause/resume with a new mode sampled on resume.
    cyc(0, 1, 16'h0030, 0, 0, 0);
    cyc(0, 0, '0, 0, 1, 0);
    cyc(0, 0, '0, 0, 0, 1);
    check("resume_up", 32'(dig_w), 32'h0031);
    cyc(0, 0, '0, 1, 0, 0);
    cyc(0, 0, '0, 0, 0, 1);
    cyc(0, 0, '0, 0, 0, 1);
    check("paused_hold", 32'(dig_w), 32'h0031);
    mode_down = 1'b1;
    cyc(0, 0, '0, 0, 0, 0);
    cyc(0, 0, '0, 0, 1, 0);
    cyc(0, 0, '0, 0, 0, 1);
    check("resume_down", 32'(dig_w), 32'h0030);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      c  = ($urandom_range(0, 49) == 0);
      l  = ($urandom_range(0, 9) == 0);
      sp = ($urandom_range(0, 19) == 0);
      st = ($urandom_range(0, 5) == 0);
      tk = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 4))
        0:       lv = 16'h5959;
        1:       lv = 16'h0001;
        2:       lv = 16'h5958;
        3:       lv = 16'h0100;
        default: lv = 16'($urandom());
      endcase
      if ($urandom_range(0, 9) == 0) mode_down = ~mode_down;
      cyc(c, l, lv, sp, st, tk);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
